// File: rtl/gray_pkg.sv
// Shared gray-code helpers for both ends of a gray pointer crossing.
// Functions work on a wide vector; zero-extension does not change any result.
package gray_pkg;

  localparam int PTR_DEFAULT = 3;
  localparam int unsigned GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int unsigned i = GRAY_MAX_W - 1; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int unsigned popcount(input logic [GRAY_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < GRAY_MAX_W; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/gray_ptr_decoder_bit_sync2.sv
// Two-flop synchroniser for a multi-bit gray bus, synchronous active-high reset.
module bit_sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sync1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      q     <= '0;
    end else begin
      sync1 <= d;
      q     <= sync1;
    end
  end

endmodule

// File: rtl/gray_ptr_decoder.sv
// Receive side of a gray pointer crossing: resynchronise, decode to binary,
// report per-cycle advance and flag/count multi-bit gray transitions.
module gray_ptr_decoder
  import gray_pkg::*;
#(
  parameter int PTR   = PTR_DEFAULT,
  parameter int ERR_W = 8
) (
  input  logic             CLK_50M,
  input  logic             RST,
  input  logic [PTR:0]     gray_in,
  output logic [PTR:0]     bin_out,
  output logic             bin_valid,
  output logic [PTR:0]     delta,
  output logic             step_err,
  output logic [ERR_W-1:0] err_count
);

  localparam int W = PTR + 1;

  logic [PTR:0] sync2;
  logic [PTR:0] gray_prev;
  logic [PTR:0] bin_next;
  logic [1:0]   fill;
  logic         illegal;

  bit_sync2 #(.W(W)) u_sync (
    .clk (CLK_50M),
    .rst (RST),
    .d   (gray_in),
    .q   (sync2)
  );

  always_comb begin
    bin_next = W'(gray2bin(GRAY_MAX_W'(sync2)));
    illegal  = popcount(GRAY_MAX_W'(sync2 ^ gray_prev)) > 1;
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      gray_prev <= '0;
      bin_out   <= '0;
      delta     <= '0;
      err_count <= '0;
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      fill      <= '0;
    end else begin
      gray_prev <= sync2;
      bin_out   <= bin_next;
      if (fill != 2'd3) fill <= fill + 2'd1;
      // valid rises on the same edge the fill counter reaches 3
      if (fill == 2'd2) bin_valid <= 1'b1;
      delta    <= bin_valid ? bin_next - bin_out : '0;
      step_err <= bin_valid & illegal;
      if (bin_valid && illegal && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_gray_ptr_decoder.sv
// Directed and randomized bench for gray_ptr_decoder against a history-queue model.
module tb_gray_ptr_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] gray_in;
  logic [3:0] bin_out;
  logic       bin_valid;
  logic [3:0] delta;
  logic       step_err;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [3:0] hist [3];
  int m_bin = 0, m_delta = 0, m_err = 0, m_cnt = 0, n_since = 0;
  bit m_valid = 0;

  gray_ptr_decoder #(.PTR(3), .ERR_W(8)) dut (
    .CLK_50M   (clk),
    .RST       (rst),
    .gray_in   (gray_in),
    .bin_out   (bin_out),
    .bin_valid (bin_valid),
    .delta     (delta),
    .step_err  (step_err),
    .err_count (err_count)
  );

  always #10 clk = ~clk;

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  // decode by search: the binary value whose gray code equals g
  function automatic int from_gray(input logic [3:0] g);
    for (int b = 0; b < 16; b++) begin
      if (to_gray(b) == g) return b;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    int nb;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 3; i++) hist[i] = '0;
      m_bin = 0; m_delta = 0; m_err = 0; m_cnt = 0; n_since = 0; m_valid = 0;
    end else begin
      // hist[0]=newest capture, hist[1]=two-flop output, hist[2]=one older
      nb      = from_gray(hist[1]);
      m_delta = m_valid ? (nb - m_bin) & 15 : 0;
      m_err   = (m_valid && $countones(hist[1] ^ hist[2]) > 1) ? 1 : 0;
      if (m_err == 1 && m_cnt < 255) m_cnt++;
      m_bin   = nb;
      n_since++;
      m_valid = (n_since >= 3);
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = gray_in;
    end
    #1;
    check("bin_out",   32'(bin_out),   32'(m_bin));
    check("bin_valid", 32'(bin_valid), 32'(m_valid));
    check("delta",     32'(delta),     32'(m_delta));
    check("step_err",  32'(step_err),  32'(m_err));
    check("err_count", 32'(err_count), 32'(m_cnt));
  endtask

  initial begin
    int cur;
    for (int i = 0; i < 3; i++) hist[i] = '0;

    // 1: reset with a non-zero pointer, then fill latency
    rst = 1'b1; gray_in = 4'b0110;
    repeat (3) step();
    check("t1_rst_bin", 32'(bin_out), 0);
    check("t1_rst_valid", 32'(bin_valid), 0);
    rst = 1'b0;
    step(); check("t1_valid_e1", 32'(bin_valid), 0);
    step(); check("t1_valid_e2", 32'(bin_valid), 0);
    step(); check("t1_valid_e3", 32'(bin_valid), 1);
    check("t1_bin_e3", 32'(bin_out), 4);

    // 2/3: clean counting sequence through the wrap
    rst = 1'b1; gray_in = 4'b0000;
    repeat (2) step();
    rst = 1'b0;
    repeat (4) step();
    for (int i = 0; i <= 16; i++) begin
      gray_in = to_gray(i % 16);
      step();
    end
    step(); check("t3_bin15", 32'(bin_out), 15);
    step(); check("t3_bin0", 32'(bin_out), 0);
    check("t3_delta_wrap", 32'(delta), 1);
    step(); check("t3_delta_hold", 32'(delta), 0);
    check("t2_no_err", 32'(err_count), 0);

    // 4: illegal jump 0 -> 2
    gray_in = 4'b0011;
    repeat (3) step();
    check("t4_step_err", 32'(step_err), 1);
    check("t4_bin", 32'(bin_out), 2);
    check("t4_delta", 32'(delta), 2);
    check("t4_err_count", 32'(err_count), 1);
    step(); check("t4_pulse_end", 32'(step_err), 0);

    // 5: saturate the error counter
    for (int i = 0; i < 300; i++) begin
      gray_in = (i % 2 == 1) ? 4'b1111 : 4'b0000;
      step();
    end
    repeat (3) step();
    check("t5_saturate", 32'(err_count), 255);

    // 6: reset mid-stream at bin_out=9, first post-reset sample differs widely
    for (int i = 0; i <= 9; i++) begin
      gray_in = to_gray(i);
      step();
    end
    repeat (3) step();
    check("t6_bin9", 32'(bin_out), 9);
    gray_in = 4'b1010; rst = 1'b1;
    step();
    check("t6_rst_bin", 32'(bin_out), 0);
    check("t6_rst_cnt", 32'(err_count), 0);
    rst = 1'b0;
    step(); check("t6_valid_e1", 32'(bin_valid), 0);
    step(); check("t6_valid_e2", 32'(bin_valid), 0);
    step(); check("t6_valid_e3", 32'(bin_valid), 1);
    check("t6_no_err_e3", 32'(step_err), 0);
    step(); check("t6_no_err_e4", 32'(step_err), 0);

    // randomized mix of legal steps, arbitrary jumps and occasional resets
    cur = from_gray(gray_in);
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(99));
      rst = (r < 2);
      if (r < 70) cur = (cur + int'($urandom_range(1))) % 16;
      else        cur = int'($urandom_range(15));
      gray_in = to_gray(cur);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
